ddr_cmd_scheduler: RTL and testbench

//  Host-side command scheduler sitting directly upstream of the DDR RAM model; feeds its ram_interface pins.

---
 rtl/ddr_cmd_scheduler_if.sv | 24 ++
 rtl/ddr_cmd_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_ddr_cmd_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_cmd_scheduler_if.sv
// rtl/ddr_cmd_scheduler_if.sv - host request/response bundle for the DDR command scheduler
interface ddr_cmd_scheduler_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [8:0]  req_addr;
    logic        req_burst;
    logic [2:0]  req_blen;
    logic [15:0] req_wdata;
    logic        wbeat_ack;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        ref_busy;

    modport master (
        output req_valid, req_we, req_addr, req_burst, req_blen, req_wdata,
        input  req_ready, wbeat_ack, rsp_valid, rsp_rdata, ref_busy
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_burst, req_blen, req_wdata,
        output req_ready, wbeat_ack, rsp_valid, rsp_rdata, ref_busy
    );
endinterface

// File: rtl/ddr_cmd_scheduler.sv
// rtl/ddr_cmd_scheduler.sv - open-row tracking DDR command scheduler with periodic refresh
module ddr_cmd_scheduler #(
    parameter int OPEN_PAGE    = 1,
    parameter int T_RCD        = 2,
    parameter int T_RP         = 2,
    parameter int T_RFC        = 5,
    parameter int REF_INTERVAL = 64,
    parameter int READ_LAT     = 1
) (
    input  logic        clk_t,
    input  logic        reset_n,
    ddr_cmd_scheduler_if.slave host,
    output logic        act,
    output logic        cs,
    output logic        rwb,
    output logic        auto_pre,
    output logic        bank_grp,
    output logic [1:0]  bank_no,
    output logic [2:0]  row_address,
    output logic [2:0]  col_address,
    output logic        burst_mode,
    output logic [2:0]  burst_len,
    output logic [15:0] datain,
    input  logic [15:0] dataout
);
    localparam int CW = 8;
    localparam int RW = $clog2(REF_INTERVAL + 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_ACT, S_CMD, S_REF} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 open_valid_q, open_valid_d;
    logic [5:0]           open_row_q, open_row_d;
    logic                 pend_q, pend_d;
    logic                 we_q, we_d;
    logic [8:0]           addr_q, addr_d;
    logic                 burst_q, burst_d;
    logic [2:0]           blen_q, blen_d;
    logic [RW-1:0]        ref_cnt_q, ref_cnt_d;
    logic [READ_LAT-1:0]  rd_pipe_q, rd_pipe_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [15:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 up_q;

    logic                 ref_pending;
    logic [CW-1:0]        nbeats;

    assign ref_pending = (ref_cnt_q == RW'(REF_INTERVAL));
    // A burst of length zero still moves one beat.
    assign nbeats = !burst_q ? CW'(1) : ((blen_q == 3'd0) ? CW'(1) : CW'(blen_q));

    // Next-state logic: refresh beats new requests, a latched request always completes.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        open_valid_d = open_valid_q;
        open_row_d   = open_row_q;
        pend_d       = pend_q;
        we_d         = we_q;
        addr_d       = addr_q;
        burst_d      = burst_q;
        blen_d       = blen_q;
        ref_cnt_d    = ref_pending ? ref_cnt_q : ref_cnt_q + RW'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ref_pending) begin
                    state_d = open_valid_q ? S_PRE : S_REF;
                end else if (up_q && host.req_valid) begin
                    pend_d  = 1'b1;
                    we_d    = host.req_we;
                    addr_d  = host.req_addr;
                    burst_d = host.req_burst;
                    blen_d  = host.req_blen;
                    if (open_valid_q && host.req_addr[8:3] == open_row_q)
                        state_d = S_CMD;
                    else if (open_valid_q)
                        state_d = S_PRE;
                    else
                        state_d = S_ACT;
                end
            end
            S_PRE: begin
                if (cnt_q == CW'(T_RP - 1)) begin
                    cnt_d        = '0;
                    open_valid_d = 1'b0;
                    state_d      = pend_q ? S_ACT : S_REF;
                end
            end
            S_ACT: begin
                if (cnt_q == CW'(T_RCD - 1)) begin
                    cnt_d        = '0;
                    open_valid_d = 1'b1;
                    open_row_d   = addr_q[8:3];
                    state_d      = S_CMD;
                end
            end
            S_CMD: begin
                if (cnt_q == nbeats - CW'(1)) begin
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                    if (OPEN_PAGE == 0) open_valid_d = 1'b0;
                end
            end
            S_REF: begin
                if (cnt_q == CW'(T_RFC - 1)) begin
                    cnt_d     = '0;
                    ref_cnt_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Read-return pipe: each read beat surfaces READ_LAT cycles later, then is registered.
    always_comb begin
        rd_pipe_d    = '0;
        rd_pipe_d[0] = (state_q == S_CMD) && !we_q;
        for (int i = 1; i < READ_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];
        rsp_valid_d = rd_pipe_q[READ_LAT-1];
        rsp_rdata_d = rd_pipe_q[READ_LAT-1] ? dataout : 16'h0;
    end

    // RAM pin and host handshake outputs decoded from the current state.
    always_comb begin
        act            = 1'b0;
        cs             = 1'b0;
        rwb            = 1'b0;
        auto_pre       = 1'b0;
        {bank_grp, bank_no, row_address} = 6'd0;
        col_address    = 3'd0;
        burst_mode     = 1'b0;
        burst_len      = 3'd0;
        datain         = 16'h0;
        host.wbeat_ack = 1'b0;
        host.ref_busy  = 1'b0;
        host.req_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                host.req_ready = up_q && !ref_pending;
                if (OPEN_PAGE != 0 && open_valid_q) begin
                    act = 1'b1;
                    {bank_grp, bank_no, row_address} = open_row_q;
                end
            end
            S_PRE: begin
                act      = 1'b1;
                auto_pre = 1'b1;
                {bank_grp, bank_no, row_address} = open_row_q;
            end
            S_ACT: begin
                act = 1'b1;
                {bank_grp, bank_no, row_address} = addr_q[8:3];
            end
            S_CMD: begin
                act         = 1'b1;
                cs          = 1'b1;
                rwb         = we_q;
                auto_pre    = (OPEN_PAGE == 0);
                {bank_grp, bank_no, row_address} = addr_q[8:3];
                col_address = addr_q[2:0];
                burst_mode  = burst_q;
                burst_len   = blen_q;
                if (we_q) begin
                    datain         = host.req_wdata;
                    host.wbeat_ack = 1'b1;
                end
            end
            S_REF: host.ref_busy = 1'b1;
            default: ;
        endcase
    end

    assign host.rsp_valid = rsp_valid_q;
    assign host.rsp_rdata = rsp_rdata_q;

    // State registers; up_q holds off acceptance for the first cycle out of reset.
    always_ff @(posedge clk_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            open_valid_q <= 1'b0;
            open_row_q   <= '0;
            pend_q       <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            burst_q      <= 1'b0;
            blen_q       <= '0;
            ref_cnt_q    <= '0;
            rd_pipe_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            up_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            open_valid_q <= open_valid_d;
            open_row_q   <= open_row_d;
            pend_q       <= pend_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            burst_q      <= burst_d;
            blen_q       <= blen_d;
            ref_cnt_q    <= ref_cnt_d;
            rd_pipe_q    <= rd_pipe_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            up_q         <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr_cmd_scheduler.sv
// tb/tb_ddr_cmd_scheduler.sv - directed table-driven bench for the DDR command scheduler
module tb_ddr_cmd_scheduler;
    logic        clk_t = 1'b0;
    logic        reset_n = 1'b0;
    logic        act, cs, rwb, auto_pre, bank_grp, burst_mode;
    logic [1:0]  bank_no;
    logic [2:0]  row_address, col_address, burst_len;
    logic [15:0] datain;
    logic [15:0] dataout = 16'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk_t = ~clk_t;

    ddr_cmd_scheduler_if hif();

    ddr_cmd_scheduler u_dut (
        .clk_t       (clk_t),
        .reset_n     (reset_n),
        .host        (hif.slave),
        .act         (act),
        .cs          (cs),
        .rwb         (rwb),
        .auto_pre    (auto_pre),
        .bank_grp    (bank_grp),
        .bank_no     (bank_no),
        .row_address (row_address),
        .col_address (col_address),
        .burst_mode  (burst_mode),
        .burst_len   (burst_len),
        .datain      (datain),
        .dataout     (dataout)
    );

    logic [52:0] all_outs;
    assign all_outs = {hif.req_ready, hif.wbeat_ack, hif.rsp_valid, hif.rsp_rdata, hif.ref_busy,
                       act, cs, rwb, auto_pre, bank_grp, bank_no, row_address, col_address,
                       burst_mode, burst_len, datain};

    // RAM model: column commands step the column per beat, wrapping within the row.
    logic [15:0] mem [0:511];
    logic [2:0]  beat = 3'd0;
    logic [2:0]  ram_col;
    assign ram_col = col_address + beat;

    always @(posedge clk_t) begin
        if (act && cs) begin
            if (rwb) mem[{bank_grp, bank_no, row_address, ram_col}] <= datain;
            else     dataout <= mem[{bank_grp, bank_no, row_address, ram_col}];
            beat <= beat + 3'd1;
        end else begin
            beat <= 3'd0;
        end
    end

    typedef struct packed {
        logic             we;
        logic [8:0]       addr;
        logic             burst;
        logic [2:0]       blen;
        logic [3:0][15:0] d;
        int               e_pre;
        int               e_act;
        int               e_cmd;
        int               e_ack;
        int               e_rsp;
        logic [3:0][15:0] e_rd;
    } vec_t;

    vec_t vecs [11];

    function automatic vec_t mkv(input logic we, input logic [8:0] addr, input logic burst,
                                 input logic [2:0] blen, input logic [63:0] d,
                                 input int p, input int a, input int c, input int k, input int r,
                                 input logic [63:0] rd);
        vec_t v;
        v.we = we; v.addr = addr; v.burst = burst; v.blen = blen; v.d = d;
        v.e_pre = p; v.e_act = a; v.e_cmd = c; v.e_ack = k; v.e_rsp = r; v.e_rd = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Issue one request from a negedge, classify every cycle until the access has drained.
    task automatic run_vec(input int idx);
        vec_t v;
        int pre, actc, cmd, ack, nrsp, idle, widx, cyc;
        bit acc, acc_now, seen, adv;
        logic [15:0] rd [4];
        v = vecs[idx];
        pre = 0; actc = 0; cmd = 0; ack = 0; nrsp = 0; idle = 0; widx = 0; cyc = 0;
        acc = 0; acc_now = 0; seen = 0;
        for (int k = 0; k < 4; k++) rd[k] = 16'h0;
        hif.req_we = v.we; hif.req_addr = v.addr; hif.req_burst = v.burst;
        hif.req_blen = v.blen; hif.req_wdata = v.d[0]; hif.req_valid = 1'b1;
        while (cyc < 80) begin
            if (!acc) begin
                if (hif.req_ready) acc_now = 1;
            end else begin
                if (act && cs) begin
                    cmd++;
                    seen = 1;
                end else if (act && !seen) begin
                    if (auto_pre) pre++;
                    else          actc++;
                end
                if (seen && !cs) idle++;
            end
            adv = acc && hif.wbeat_ack;
            if (adv) ack++;
            if (hif.rsp_valid) begin
                if (nrsp < 4) rd[nrsp] = hif.rsp_rdata;
                nrsp++;
            end
            if (idle >= 4) break;
            @(posedge clk_t);
            #1;
            if (acc_now) begin
                acc = 1; acc_now = 0; hif.req_valid = 1'b0;
            end
            if (adv) begin
                widx++;
                hif.req_wdata = (widx < 4) ? v.d[widx] : 16'h0;
            end
            @(negedge clk_t);
            cyc++;
        end
        hif.req_valid = 1'b0;
        chk($sformatf("v%0d_done", idx), idle, 4);
        chk($sformatf("v%0d_pre", idx), pre, v.e_pre);
        chk($sformatf("v%0d_act", idx), actc, v.e_act);
        chk($sformatf("v%0d_cmd", idx), cmd, v.e_cmd);
        chk($sformatf("v%0d_ack", idx), ack, v.e_ack);
        chk($sformatf("v%0d_nrsp", idx), nrsp, v.e_rsp);
        for (int k = 0; k < 4; k++)
            if (k < v.e_rsp) chk($sformatf("v%0d_rd%0d", idx, k), rd[k], v.e_rd[k]);
    endtask

    initial begin
        int pre, refc, cyc;
        bit bad, done;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0;
        hif.req_valid = 1'b0; hif.req_we = 1'b0; hif.req_addr = 9'h0;
        hif.req_burst = 1'b0; hif.req_blen = 3'd0; hif.req_wdata = 16'h0;

        //               we  addr    bst blen data(d3..d0)                               pre act cmd ack rsp  rdata(r3..r0)
        vecs[0]  = mkv(1'b1, 9'h19D, 1'b0, 3'd0, {48'h0, 16'hA5A5},                     0, 2, 1, 1, 0, 64'h0);
        vecs[1]  = mkv(1'b0, 9'h19D, 1'b0, 3'd0, 64'h0,                                 0, 0, 1, 0, 1, {48'h0, 16'hA5A5});
        vecs[2]  = mkv(1'b1, 9'h199, 1'b0, 3'd0, {48'h0, 16'h1234},                     0, 0, 1, 1, 0, 64'h0);
        vecs[3]  = mkv(1'b0, 9'h199, 1'b0, 3'd0, 64'h0,                                 0, 0, 1, 0, 1, {48'h0, 16'h1234});
        vecs[4]  = mkv(1'b0, 9'h19A, 1'b0, 3'd0, 64'h0,                                 0, 0, 1, 0, 1, 64'h0);
        vecs[5]  = mkv(1'b1, 9'h1A5, 1'b0, 3'd0, {48'h0, 16'hBEEF},                     2, 2, 1, 1, 0, 64'h0);
        vecs[6]  = mkv(1'b1, 9'h19E, 1'b1, 3'd4, {16'h4, 16'h3, 16'h2, 16'h1},          0, 2, 4, 4, 0, 64'h0);
        vecs[7]  = mkv(1'b0, 9'h19E, 1'b1, 3'd4, 64'h0,                                 0, 0, 4, 0, 4, {16'h4, 16'h3, 16'h2, 16'h1});
        vecs[8]  = mkv(1'b0, 9'h199, 1'b0, 3'd0, 64'h0,                                 0, 0, 1, 0, 1, {48'h0, 16'h4});
        vecs[9]  = mkv(1'b0, 9'h19F, 1'b1, 3'd0, 64'h0,                                 0, 0, 1, 0, 1, {48'h0, 16'h2});
        vecs[10] = mkv(1'b0, 9'h0EA, 1'b0, 3'd0, 64'h0,                                 0, 2, 1, 0, 1, {48'h0, 16'h1111});

        @(negedge clk_t);
        chk("reset_outs", all_outs, 53'h0);
        @(negedge clk_t);
        reset_n = 1'b1;

        for (int i = 0; i <= 5; i++) run_vec(i);

        // Refresh with row 4 still open: precharge, then the refresh window, host held off.
        pre = 0; refc = 0; cyc = 0; bad = 0; done = 0;
        while (cyc < 120 && !done) begin
            if (hif.ref_busy) begin
                refc++;
                if (act || cs || hif.req_ready) bad = 1;
            end else if (refc > 0) begin
                done = 1;
            end else if (act && auto_pre && !cs) begin
                pre++;
                if (hif.req_ready) bad = 1;
            end
            if (!done) begin
                @(negedge clk_t);
                cyc++;
            end
        end
        chk("t4_done", done, 1);
        chk("t4_pre_cycles", pre, 2);
        chk("t4_ref_cycles", refc, 5);
        chk("t4_ready_low", bad, 0);
        chk("t4_ready_after", hif.req_ready, 1);
        chk("t4_row_closed", act, 0);

        for (int i = 6; i <= 9; i++) run_vec(i);

        // Reset dropped in the middle of a burst write, after exactly one beat landed.
        hif.req_we = 1'b1; hif.req_addr = 9'h0EA; hif.req_burst = 1'b1;
        hif.req_blen = 3'd4; hif.req_wdata = 16'h1111; hif.req_valid = 1'b1;
        cyc = 0;
        while (!hif.req_ready && cyc < 20) begin
            @(negedge clk_t);
            cyc++;
        end
        @(posedge clk_t);
        #1 hif.req_valid = 1'b0;
        @(negedge clk_t);
        while (!cs && cyc < 40) begin
            @(negedge clk_t);
            cyc++;
        end
        chk("t6_in_cmd", cs, 1);
        @(posedge clk_t);
        #1 hif.req_wdata = 16'h2222;
        @(negedge clk_t);
        #2 reset_n = 1'b0;
        #1 chk("t6_reset_outs", all_outs, 53'h0);
        @(negedge clk_t);
        @(negedge clk_t);
        reset_n = 1'b1;
        hif.req_wdata = 16'h0; hif.req_burst = 1'b0; hif.req_blen = 3'd0;
        run_vec(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
